// File: rtl/fp32_maxmin_reduce_seq.sv
// Sequencer that folds a stream of FP32 elements through an external max/min
// comparator, one (accumulator, element) pair at a time, and returns one result per vector.
module fp32_maxmin_reduce_seq #(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned CMP_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_is_max,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             cmp_valid,
    output logic             cmp_is_max,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic             cmp_res_valid,
    input  logic [31:0]      cmp_res,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [31:0]      o_result,
    output logic             o_nan,
    output logic             o_err,
    output logic             o_busy
);

    localparam int unsigned TMO_W = (CMP_TIMEOUT < 2) ? 1 : $clog2(CMP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_WAIT_ELEM,
        S_WAIT_RES,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        acc_q, acc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               nan_q, nan_d;
    logic               err_q, err_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic               cmp_is_max_q, cmp_is_max_d;
    logic [31:0]        cmp_a_q, cmp_a_d;
    logic [31:0]        cmp_b_q, cmp_b_d;
    logic               o_valid_q, o_valid_d;
    logic [31:0]        res_q, res_d;
    logic               s_ready_q, s_ready_d;
    logic               busy_q, busy_d;

    logic               s_hs;
    logic [LEN_W-1:0]   cnt_inc;
    logic [TMO_W-1:0]   tmo_inc;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != '0);
    endfunction

    assign s_hs    = s_valid && s_ready_q;
    assign cnt_inc = cnt_q + LEN_W'(1);
    assign tmo_inc = tmo_q + TMO_W'(1);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        tmo_d        = tmo_q;
        nan_d        = nan_q;
        err_d        = err_q;
        cmp_valid_d  = 1'b0;
        cmp_is_max_d = cmp_is_max_q;
        cmp_a_d      = cmp_a_q;
        cmp_b_d      = cmp_b_q;
        res_d        = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    len_d        = i_len;
                    cmp_is_max_d = i_is_max;
                    nan_d        = 1'b0;
                    err_d        = 1'b0;
                    if (i_len == '0) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                if (s_hs) begin
                    acc_d = s_data;
                    cnt_d = LEN_W'(1);
                    if (is_nan(s_data)) nan_d = 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        res_d   = s_data;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_ELEM;
                    end
                end
            end
            S_WAIT_ELEM: begin
                if (s_hs) begin
                    cmp_a_d     = acc_q;
                    cmp_b_d     = s_data;
                    cmp_valid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                // A result arriving on the timeout cycle still wins over the abort.
                if (cmp_res_valid) begin
                    acc_d = cmp_res;
                    cnt_d = cnt_inc;
                    if (cmp_res == '1) nan_d = 1'b1;
                    if (cnt_inc == len_q) begin
                        res_d   = cmp_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_ELEM;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(CMP_TIMEOUT)) begin
                        err_d   = 1'b1;
                        res_d   = acc_q;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (o_valid_q && o_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake-facing outputs are registered, so they follow the next state.
        s_ready_d = (state_d == S_FIRST) || (state_d == S_WAIT_ELEM);
        o_valid_d = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            tmo_q        <= '0;
            nan_q        <= 1'b0;
            err_q        <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_is_max_q <= 1'b0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            o_valid_q    <= 1'b0;
            res_q        <= '0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            tmo_q        <= tmo_d;
            nan_q        <= nan_d;
            err_q        <= err_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_is_max_q <= cmp_is_max_d;
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
            o_valid_q    <= o_valid_d;
            res_q        <= res_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign cmp_valid  = cmp_valid_q;
    assign cmp_is_max = cmp_is_max_q;
    assign cmp_a      = cmp_a_q;
    assign cmp_b      = cmp_b_q;
    assign o_valid    = o_valid_q;
    assign o_result   = res_q;
    assign o_nan      = nan_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/fp32_maxmin_reduce_seq.md
Name: fp32_maxmin_reduce_seq

Overview:
- Upstream sequencer for the two-operand FP32 max/min comparator stage.
- Accepts a stream of FP32 elements over a valid/ready handshake and issues (accumulator, element) pairs to the comparator, one at a time.
- Folds each comparator result back into the accumulator and presents one reduced max or min value per vector, with NaN and error status.

Parameters:
- LEN_W, 16, width of the vector-length field. Maximum vector length is 2^LEN_W-1.
- CMP_TIMEOUT, 8, cycles to wait in WAIT_RES for cmp_res_valid before aborting with an error.

Ports:
- clk  in  1  single clock for the block.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse that starts a reduction. Honoured only in IDLE.
- i_len  in  LEN_W  element count, sampled on an accepted i_start.
- i_is_max  in  1  operation select, sampled on an accepted i_start: 1 = max, 0 = min.
- s_valid  in  1  element valid.
- s_ready  out  1  element ready.
- s_data  in  32  FP32 element.
- cmp_valid  out  1  comparator issue pulse.
- cmp_is_max  out  1  operation select to the comparator.
- cmp_a  out  32  accumulator operand to the comparator.
- cmp_b  out  32  element operand to the comparator.
- cmp_res_valid  in  1  comparator result valid.
- cmp_res  in  32  comparator result.
- o_valid  out  1  reduced result valid. Held until o_ready.
- o_ready  in  1  result consumer ready.
- o_result  out  32  reduced value.
- o_nan  out  1  a NaN was seen anywhere in the vector.
- o_err  out  1  len==0 or comparator timeout.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs, the accumulator, the element counter and the timeout counter clear to 0. FSM goes to IDLE.
- Reset is asynchronous and is legal mid-operation. A partial reduction is discarded and no o_valid is produced.
- Every output is registered.

FSM states: IDLE, FIRST, WAIT_ELEM, WAIT_RES, DONE.
- IDLE:
  - On i_start, latch i_len into len and i_is_max into cmp_is_max; clear nan and err.
  - If i_len==0, go to DONE with o_result=0 and o_err=1. Otherwise go to FIRST.
  - i_start is ignored in every state except IDLE.
- FIRST:
  - s_ready=1. On handshake, acc<=s_data and cnt<=1.
  - nan is set if s_data has exp==8'hFF and mant!=0.
  - If len==1, go to DONE (no compare issued). Otherwise go to WAIT_ELEM.
- WAIT_ELEM:
  - s_ready=1. On handshake at cycle T: cmp_a<=acc, cmp_b<=s_data, and cmp_valid is high for exactly one cycle (T+1). Go to WAIT_RES and clear the timeout counter.
- WAIT_RES:
  - s_ready=0. The nominal comparator latency puts cmp_res_valid at T+3.
  - On cmp_res_valid: acc<=cmp_res and cnt<=cnt+1. nan is set if cmp_res==32'hFFFFFFFF.
  - Then go to DONE if cnt+1==len, else to WAIT_ELEM.
  - The timeout counter increments each cycle. On reaching CMP_TIMEOUT without a result, set err=1, o_result<=acc, and go to DONE.
- DONE:
  - o_valid=1, with o_result, o_nan and o_err stable.
  - On o_valid&&o_ready, o_valid drops the next cycle and the FSM returns to IDLE. A new i_start is accepted from the following cycle.
- cmp_res_valid outside WAIT_RES is ignored.
- cmp_a, cmp_b and cmp_is_max hold their values between issues.

Throughput and width rules:
- With s_valid held high, one element is accepted every 4 cycles after the first.
- A vector of length N (N>=2) with o_ready=1 completes in 4N-2 cycles from i_start to o_valid.
- cnt is LEN_W bits and never wraps, because len is at most 2^LEN_W-1.
- Elements arriving with s_valid while s_ready=0 are not consumed and stay with the upstream stream.

Test Plan:
- Max of 4 elements: i_is_max=1, len=4, stream 0x3F800000, 0xC0000000, 0x40400000, 0x00000000 -> exactly 3 cmp_valid pulses; o_valid with o_result=0x40400000, o_nan=0, o_err=0.
- Min of 3 elements: i_is_max=0, len=3, stream 0x40000000, 0xBF800000, 0x3F800000 -> cmp_is_max=0 on every issue; o_result equals the final cmp_res supplied by the comparator model.
- len=1 with element 0x7F800000 -> no cmp_valid; o_result=0x7F800000, o_nan=0. len=0 -> o_valid one cycle after start with o_result=0 and o_err=1, and s_ready stays low throughout.
- NaN first element 0x7FC00000, len=2, model returns 0xFFFFFFFF -> o_result=0xFFFFFFFF, o_nan=1.
- Backpressure: s_valid toggles and o_ready is held low 5 cycles in DONE -> no element lost or duplicated; o_valid and o_result stay stable until o_ready; a second i_start during busy is ignored.
- Comparator model withholds cmp_res_valid -> o_err=1 after CMP_TIMEOUT cycles, with o_result equal to the last acc. Asserting rstn low in WAIT_RES -> all outputs are 0 immediately and the FSM is in IDLE.
